// File: rtl/axis_frame_dispatcher.sv
// AXI-stream frame dispatcher: steers whole frames from one input to one of M_COUNT outputs,
// choosing among available ports (fixed or round-robin) and locking the port until tlast.
module axis_frame_dispatcher #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [M_COUNT-1:0]           m_axis_tvalid,
  input  logic [M_COUNT-1:0]           m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  input  logic [M_COUNT-1:0]           m_avail,
  output logic                         busy,
  output logic [$clog2(M_COUNT)-1:0]   sel_encoded
);

  localparam int SEL_WIDTH = $clog2(M_COUNT);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [M_COUNT-1:0]    mask_q, mask_d;
  logic                  busy_q, busy_d;
  logic                  s_ready_q, s_ready_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [USER_WIDTH-1:0] out_user_q, out_user_d;

  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic [USER_WIDTH-1:0] skid_user_q, skid_user_d;

  logic [M_COUNT-1:0]    masked_avail;
  logic [M_COUNT-1:0]    cand;
  logic [SEL_WIDTH-1:0]  pick_idx;
  logic                  out_ready;
  logic                  out_fire;
  logic                  s_fire;
  logic                  busy_clear;
  logic                  can_select;

  assign masked_avail = m_avail & mask_q;
  assign cand = ((ROUND_ROBIN != 0) && (masked_avail != '0)) ? masked_avail : m_avail;

  // Scan downward so the lowest set bit is the one left in pick_idx.
  always_comb begin
    pick_idx = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_idx = SEL_WIDTH'(i);
      end
    end
  end

  assign out_ready  = m_axis_tready[sel_q];
  assign out_fire   = out_valid_q & out_ready;
  assign s_fire     = s_ready_q & s_axis_tvalid;
  assign busy_clear = out_fire & out_last_q;
  // Selection may overlap the cycle in which the previous frame's tlast leaves the output.
  assign can_select = (state_q == ST_IDLE) && s_axis_tvalid && (m_avail != '0) &&
                      (!busy_q || busy_clear);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    mask_d       = mask_q;
    busy_d       = busy_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_user_d   = out_user_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_user_d  = skid_user_q;

    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_user_d   = skid_user_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_fire;
        if (s_fire) begin
          out_data_d = s_axis_tdata;
          out_last_d = s_axis_tlast;
          out_user_d = s_axis_tuser;
        end
      end
    end else if (s_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_axis_tdata;
      skid_last_d  = s_axis_tlast;
      skid_user_d  = s_axis_tuser;
    end

    if (busy_clear) begin
      busy_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (can_select) begin
          state_d = ST_ACTIVE;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          if (ROUND_ROBIN != 0) begin
            mask_d = {M_COUNT{1'b1}} << (int'(pick_idx) + 1);
          end
        end
      end
      default: begin
        if (s_fire && s_axis_tlast) begin
          state_d = ST_IDLE;
        end
      end
    endcase

    s_ready_d = (state_d == ST_ACTIVE) && !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      mask_q       <= '0;
      busy_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_user_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_user_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mask_q       <= mask_d;
      busy_q       <= busy_d;
      s_ready_q    <= s_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_user_q  <= skid_user_d;
    end
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tvalid = out_valid_q ? ({{(M_COUNT-1){1'b0}}, 1'b1} << sel_q) : '0;
  assign busy          = busy_q;
  assign sel_encoded   = sel_q;

endmodule

// File: tb/tb_axis_frame_dispatcher.sv
// Scoreboard bench for axis_frame_dispatcher: a round-robin instance plus a fixed-priority one.
module tb_axis_frame_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [0:0] s_tuser = '0;
  logic [7:0] m_tdata;
  logic [3:0] m_tvalid;
  logic [3:0] m_tready = 4'b1111;
  logic       m_tlast;
  logic [0:0] m_tuser;
  logic [3:0] m_avail = 4'b0000;
  logic       busy;
  logic [1:0] sel_enc;

  logic [7:0] f_s_tdata = '0;
  logic       f_s_tvalid = 1'b0;
  logic       f_s_tready;
  logic       f_s_tlast = 1'b0;
  logic [0:0] f_s_tuser = '0;
  logic [7:0] f_m_tdata;
  logic [3:0] f_m_tvalid;
  logic [3:0] f_m_tready = 4'b1111;
  logic       f_m_tlast;
  logic [0:0] f_m_tuser;
  logic [3:0] f_m_avail = 4'b0000;
  logic       f_busy;
  logic [1:0] f_sel_enc;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cur_port = 0;

  always #5 clk = ~clk;

  axis_frame_dispatcher #(
    .M_COUNT(4), .DATA_WIDTH(8), .USER_WIDTH(1), .ROUND_ROBIN(1)
  ) u_rr (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_avail(m_avail), .busy(busy), .sel_encoded(sel_enc)
  );

  axis_frame_dispatcher #(
    .M_COUNT(4), .DATA_WIDTH(8), .USER_WIDTH(1), .ROUND_ROBIN(0)
  ) u_fixed (
    .clk(clk), .rst(rst),
    .s_axis_tdata(f_s_tdata), .s_axis_tvalid(f_s_tvalid), .s_axis_tready(f_s_tready),
    .s_axis_tlast(f_s_tlast), .s_axis_tuser(f_s_tuser),
    .m_axis_tdata(f_m_tdata), .m_axis_tvalid(f_m_tvalid), .m_axis_tready(f_m_tready),
    .m_axis_tlast(f_m_tlast), .m_axis_tuser(f_m_tuser),
    .m_avail(f_m_avail), .busy(f_busy), .sel_encoded(f_sel_enc)
  );

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard on every output handshake and checks hold-stability under stall.
  task automatic monitor();
    logic        stalled = 1'b0;
    logic [13:0] held = '0;
    logic [3:0]  exp_v;
    beat_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        checks++;
        if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== held) begin
          errors++;
          $display("FAIL stall_stable got %h want %h", {m_tvalid, m_tdata, m_tlast, m_tuser}, held);
        end
      end
      if ((m_tvalid & m_tready) != 4'b0000) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got valid=%b data=%h", m_tvalid, m_tdata);
        end else begin
          e = exp_q.pop_front();
          exp_v = 4'b0001 << e.port;
          if (m_tvalid !== exp_v || m_tdata !== e.data || m_tlast !== e.last ||
              m_tuser !== e.user) begin
            errors++;
            $display("FAIL out_beat got valid=%b data=%h last=%b user=%b want valid=%b data=%h last=%b user=%b",
                     m_tvalid, m_tdata, m_tlast, m_tuser, exp_v, e.data, e.last, e.user);
          end
        end
      end
      stalled = (m_tvalid != 4'b0000) && ((m_tvalid & m_tready) == 4'b0000);
      held = {m_tvalid, m_tdata, m_tlast, m_tuser};
    end
  endtask

  // Call aligned just after a rising edge; returns aligned just after the accepting edge.
  task automatic drive_beat(input logic [7:0] d, input logic l, output int waits);
    logic ok = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = d[0];
    s_tvalid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
      waits++;
      if (waits > 300) break;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL handshake_timeout got tready=%b want 1 data=%h", s_tready, d);
    end else begin
      exp_q.push_back('{port: cur_port[1:0], data: d, last: l, user: d[0]});
    end
    align();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] base, input bit chk_rate);
    int w;
    int exp_w;
    for (int i = 0; i < len; i++) begin
      drive_beat(base + 8'(i), (i == len - 1), w);
      if (chk_rate) begin
        exp_w = (i == 0) ? 1 : 0;
        checks++;
        if (w !== exp_w) begin
          errors++;
          $display("FAIL beat_rate got wait=%0d want %0d beat=%0d", w, exp_w, i);
        end
      end
    end
  endtask

  task automatic check_sel(input int want);
    checks++;
    if (sel_enc !== want[1:0]) begin
      errors++;
      $display("FAIL sel_encoded got %0d want %0d", sel_enc, want);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d beats pending want 0", exp_q.size());
      exp_q.delete();
    end
    align();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_drain got %b want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b0 || m_tvalid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valid got tready=%b valid=%b want 0 0000", s_tready, m_tvalid);
    end
    checks++;
    if (m_tdata !== 8'h00 || m_tlast !== 1'b0 || m_tuser !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got data=%h last=%b user=%b want 00 0 0", m_tdata, m_tlast, m_tuser);
    end
    checks++;
    if (busy !== 1'b0 || sel_enc !== 2'd0) begin
      errors++;
      $display("FAIL reset_busy_sel got busy=%b sel=%0d want 0 0", busy, sel_enc);
    end
    align();
    rst = 1'b0;
    align();
  endtask

  task automatic test_rr_even();
    m_avail  = 4'b1111;
    m_tready = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      cur_port = f % 4;
      send_frame(3, 8'(f * 16), 1'b1);
      check_sel(cur_port);
    end
    wait_drain();
  endtask

  task automatic test_rr_skip();
    int ports[4] = '{1, 3, 1, 3};
    m_avail = 4'b1010;
    for (int f = 0; f < 4; f++) begin
      cur_port = ports[f];
      send_frame(2, 8'(8'h80 + f * 4), 1'b0);
      check_sel(cur_port);
    end
    wait_drain();
    m_avail  = 4'b0001;
    cur_port = 0;
    send_frame(2, 8'h90, 1'b0);
    check_sel(0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    bit         done = 1'b0;
    m_avail  = 4'b0100;
    cur_port = 2;
    fork
      begin
        send_frame(6, 8'hC0, 1'b0);
        done = 1'b1;
      end
      begin
        int k = 0;
        while (!done) begin
          m_tready[2] = pat[k % 4];
          k++;
          align();
          checks++;
          if (exp_q.size() > 2) begin
            errors++;
            $display("FAIL skid_occupancy got %0d beats in flight want <= 2", exp_q.size());
          end
        end
      end
    join
    m_tready = 4'b1111;
    check_sel(2);
    wait_drain();
  endtask

  task automatic test_avail_drop_and_reset();
    int w;
    m_avail  = 4'b1111;
    cur_port = 3;
    for (int i = 0; i < 5; i++) begin
      drive_beat(8'(8'hD0 + i), (i == 4), w);
      if (i == 1) m_avail = 4'b0111;
    end
    check_sel(3);
    wait_drain();

    m_avail  = 4'b1111;
    cur_port = 0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(8'(8'hE0 + i), 1'b0, w);
    end
    rst = 1'b1;
    align();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (m_tvalid !== 4'b0000 || s_tready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got valid=%b tready=%b busy=%b want 0000 0 0",
               m_tvalid, s_tready, busy);
    end
    checks++;
    if (sel_enc !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_sel got %0d want 0", sel_enc);
    end
    align();

    m_avail  = 4'b1100;
    cur_port = 2;
    send_frame(2, 8'hF0, 1'b0);
    check_sel(2);
    wait_drain();
  endtask

  task automatic test_back_to_back_single();
    int w;
    m_avail  = 4'b0000;
    s_tdata  = 8'h51;
    s_tlast  = 1'b1;
    s_tuser  = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (s_tready !== 1'b0 || m_tvalid !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL blocked_no_avail got tready=%b valid=%b busy=%b want 0 0000 0",
                 s_tready, m_tvalid, busy);
      end
    end
    align();
    m_avail  = 4'b0001;
    cur_port = 0;
    for (int f = 0; f < 4; f++) begin
      drive_beat(8'(8'h51 + f * 2), 1'b1, w);
      checks++;
      if (w !== 1) begin
        errors++;
        $display("FAIL single_gap got wait=%0d want 1 frame=%0d", w, f);
      end
    end
    check_sel(0);
    wait_drain();
  endtask

  task automatic test_fixed_priority();
    logic [7:0] d;
    logic       l;
    int         n;
    f_m_avail = 4'b0110;
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 2; b++) begin
        d = 8'(8'hA0 + f * 2 + b);
        l = (b == 1);
        f_s_tdata  = d;
        f_s_tlast  = l;
        f_s_tuser  = d[0];
        f_s_tvalid = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!f_s_tready && n < 50);
        align();
        f_s_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (f_m_tvalid !== 4'b0010 || f_m_tdata !== d || f_m_tlast !== l) begin
          errors++;
          $display("FAIL fixed_beat got valid=%b data=%h last=%b want 0010 %h %b",
                   f_m_tvalid, f_m_tdata, f_m_tlast, d, l);
        end
        align();
      end
      checks++;
      if (f_sel_enc !== 2'd1) begin
        errors++;
        $display("FAIL fixed_sel got %0d want 1", f_sel_enc);
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_rr_even();
    test_rr_skip();
    test_backpressure();
    test_avail_drop_and_reset();
    test_back_to_back_single();
    test_fixed_priority();
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_frame_dispatcher.md
Name: axis_frame_dispatcher

Overview:
- Inverse of the team's many-to-one arbiter: steers whole AXI-stream frames from one slave input to one of M_COUNT master outputs.
- At each frame start, picks a destination among outputs flagged available (fixed or round-robin priority), then locks that destination until the frame's tlast is accepted.
- Used ahead of parallel processing lanes or per-queue FIFOs for load distribution.

Parameters:
- M_COUNT, 4, number of output ports (2..32).
- DATA_WIDTH, 8, tdata width.
- USER_WIDTH, 1, tuser width.
- ROUND_ROBIN, 1. 1 = round-robin over available ports. 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of frame
- s_axis_tuser  in  USER_WIDTH  sideband, forwarded
- m_axis_tdata  out  DATA_WIDTH  shared output data bus
- m_axis_tvalid  out  M_COUNT  one-hot per-port valid
- m_axis_tready  in  M_COUNT  per-port ready
- m_axis_tlast  out  1  shared tlast
- m_axis_tuser  out  USER_WIDTH  shared tuser
- m_avail  in  M_COUNT  per-port "can accept a new frame"; sampled only at selection
- busy  out  1  frame in progress
- sel_encoded  out  $clog2(M_COUNT)  current or last selected port

Behaviour:
- Reset values:
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata/tlast/tuser=0.
  - busy=0, sel_encoded=0.
  - rr mask=0; skid buffer empty; state IDLE.
- State IDLE:
  - s_axis_tready=0.
  - If s_axis_tvalid=1 and (m_avail!=0): select a port, register sel_encoded, set busy=1, go to ACTIVE on the next clock.
  - Otherwise stay in IDLE.
  - Selection latency: 1 cycle from tvalid to entering ACTIVE.
- Selection:
  - ROUND_ROBIN=0: lowest set bit of m_avail.
  - ROUND_ROBIN=1: lowest set bit of (m_avail & mask); if that is zero, lowest set bit of m_avail. Mask is then set to ones above the chosen index (mask = ~0 << (sel+1)).
  - The mask is updated only on selection.
- State ACTIVE:
  - s_axis_tready = output stage can accept, i.e. skid buffer empty.
  - The s_axis_tready register is computed from the next-state of the output stage; there is no combinational path from m_axis_tready to s_axis_tready.
  - An accepted beat appears on the outputs with m_axis_tvalid[sel] asserted one cycle later. Bits other than sel stay 0.
- Output stage:
  - Output register plus one-entry skid buffer.
  - Full throughput (1 beat/cycle) when m_axis_tready[sel] is held high.
  - Output beats are held stable while m_axis_tvalid[sel]=1 and m_axis_tready[sel]=0.
- Frame end:
  - Acceptance of an input beat with tlast=1 deasserts s_axis_tready the next cycle and returns to IDLE.
  - busy deasserts when the tlast beat is accepted at the output.
  - A new selection is not made until busy=0, so output-side frames never interleave.
  - Minimum gap between frames: 1 idle cycle on the input side.
- m_avail changes:
  - Changes during ACTIVE are ignored; the locked port keeps the frame.
  - m_avail=0 while in IDLE blocks indefinitely. The input is not dropped.
- Single-beat frame (tvalid and tlast on the same beat) is legal: one output beat with tlast=1.
- m_axis_tready on non-selected ports is ignored.
- Reset mid-frame:
  - Outputs go to reset values on the next edge; skid contents are discarded.
  - The mask is cleared, so the first post-reset selection is the lowest available port.
- Input tvalid deasserted mid-frame: the dispatcher stays ACTIVE with no output valid until the stream resumes.

Test Plan:
- Round robin, even spread: m_avail=4'b1111, eight 3-beat frames, all ready=1 -> frames land on ports 0,1,2,3,0,1,2,3; sel_encoded follows; no beats lost; 1 beat/cycle inside each frame.
- Round robin, skipping unavailable ports: m_avail=4'b1010, four frames -> ports 1,3,1,3. After m_avail changes to 4'b0001, the next frame goes to port 0.
- Fixed priority: ROUND_ROBIN=0, m_avail=4'b0110, three frames -> all go to port 1.
- Backpressure on the locked port: m_axis_tready[2] toggles 1,0,0,1 during a 6-beat frame to port 2.
  - Data order and tlast are preserved; at most one beat is buffered beyond the output register.
  - Output is stable while stalled; s_axis_tready=0 within one cycle of the skid buffer filling.
- m_avail drops mid-frame and reset mid-frame:
  - Drop m_avail[sel] at beat 2 of 5 -> the frame completes on the same port.
  - Assert rst at beat 3 -> the next cycle has all m_axis_tvalid=0, s_axis_tready=0, busy=0.
  - The first post-reset frame with m_avail=4'b1100 goes to port 2.
- Single-beat frames back-to-back with m_avail=0 at start: no output and tready=0 until m_avail=4'b0001. Then each 1-beat frame is dispatched with tlast=1 and one idle input cycle between frames.
